// File: rtl/adder_subtractor_seq.sv
// Multi-cycle two's-complement adder/subtractor: sums WIDTH-bit operands CHUNK bits
// per clock under a start/busy/done handshake, with carry/borrow and signed overflow.
module adder_subtractor_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] part_reg, part_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic             m_reg, m_next;
  logic             carry_reg, carry_next;
  logic             bout_reg, bout_next;
  logic             ovf_reg, ovf_next;
  logic             done_reg, done_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [CHUNK-1:0] a_lo;
  logic [CHUNK-1:0] b_lo;
  logic [CHUNK:0]   sum;
  logic             last;

  // Latched operands shift right each cycle, so the current chunk is always the low CHUNK bits.
  assign a_lo = a_reg[CHUNK-1:0];
  assign b_lo = b_reg[CHUNK-1:0] ^ {CHUNK{m_reg}};
  assign sum  = {1'b0, a_lo} + {1'b0, b_lo} + {{CHUNK{1'b0}}, carry_reg};
  assign last = (cnt_reg == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      part_reg  <= '0;
      d_reg     <= '0;
      m_reg     <= 1'b0;
      carry_reg <= 1'b0;
      bout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      part_reg  <= part_next;
      d_reg     <= d_next;
      m_reg     <= m_next;
      carry_reg <= carry_next;
      bout_reg  <= bout_next;
      ovf_reg   <= ovf_next;
      done_reg  <= done_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    part_next  = part_reg;
    d_next     = d_reg;
    m_next     = m_reg;
    carry_next = carry_reg;
    bout_next  = bout_reg;
    ovf_next   = ovf_reg;
    done_next  = 1'b0;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          m_next     = M;
          carry_next = M;
          cnt_next   = '0;
          part_next  = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        // New chunk enters at the top; after N cycles the result is fully aligned.
        part_next  = (part_reg >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        carry_next = sum[CHUNK];
        a_next     = a_reg >> CHUNK;
        b_next     = b_reg >> CHUNK;
        cnt_next   = cnt_reg + CW'(1);
        if (last) begin
          // On the last chunk the low bits of a_reg/b_lo hold the operand sign bits.
          d_next     = part_next;
          bout_next  = sum[CHUNK] ^ m_reg;
          ovf_next   = (a_lo[CHUNK-1] == b_lo[CHUNK-1]) && (sum[CHUNK-1] != a_lo[CHUNK-1]);
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg == CALC);
  assign done = done_reg;
  assign d    = d_reg;
  assign bout = bout_reg;
  assign ovf  = ovf_reg;

endmodule
